axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

Packet-locked round-robin arbiter that shares one AXI-Stream datapath (for example `axis_rotate`) between `NUM_REQ` AXI-Stream requesters. It grants one requester at a time and holds that grant until the requester's `tlast` beat transfers. It then passes priority to the next requester in cyclic order. It sits directly upstream of the shared stream block and is exercised by the `axi_master_model`/`axi_slave_model` benches with interruptions enabled.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 32: tdata width per stream.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tdata` in `NUM_REQ*DATA_WIDTH`: requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_axis_tvalid` in `NUM_REQ`: per-requester valid.
- `s_axis_tlast` in `NUM_REQ`: per-requester end of packet.
- `s_axis_tready` out `NUM_REQ`: per-requester ready.
- `m_axis_tdata` out `DATA_WIDTH`: to the shared datapath.
- `m_axis_tvalid` out 1.
- `m_axis_tlast` out 1.
- `m_axis_tready` in 1.
- `grant` out `NUM_REQ`: one-hot current owner, all-zero when idle.
- `busy` out 1: high in LOCK.

## Operation
- FSM states: IDLE and LOCK. Registers: `state`, `grant_idx` (`$clog2(NUM_REQ)` bits) and `ptr` (next-priority index).
- **IDLE**
  - `m_axis_tvalid`=0, all `s_axis_tready`=0, `grant`=0.
  - If any `s_axis_tvalid` is set, select the first set index scanning `ptr`, `ptr+1`, … modulo `NUM_REQ`, load it into `grant_idx`, and go to LOCK.
  - Otherwise stay in IDLE.
- **LOCK**, with g = `grant_idx`:
  - `m_axis_tdata`, `m_axis_tvalid` and `m_axis_tlast` are the combinational copies of requester g's signals.
  - `s_axis_tready[g]` = `m_axis_tready`; all other readies are 0.
  - `grant` = one-hot(g).
- **End of packet:** when `m_axis_tvalid & m_axis_tready & m_axis_tlast` in LOCK, go to IDLE and set `ptr` <= (g+1) mod `NUM_REQ`.
  - Wrap-around: g = `NUM_REQ-1` gives `ptr`=0.
- **No beat splitting:** a granted requester that drops `tvalid` mid-packet keeps the lock.
  - The arbiter waits indefinitely and never re-arbitrates mid-packet.
- **Non-granted requesters:** their `tvalid` and `tdata` are ignored and never observed downstream.
- **Simultaneous requests:** resolved purely by round-robin order from `ptr`; there is no fixed priority.
- **Reset values:** `state`=IDLE, `ptr`=0, `grant_idx`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `s_axis_tready`=0, `grant`=0, `busy`=0.
- **Reset mid-packet:**
  - While `rst`=1, `m_axis_tvalid` and all `s_axis_tready` are forced to 0 combinationally, so no beat transfers in a reset cycle.
  - The partial packet is abandoned. After reset the arbiter restarts from requester 0 priority.
- **Payload integrity:** tdata is not modified. The arbiter introduces no storage, so no data is lost or duplicated.

## Timing
- Arbitration bubble: the request is seen in IDLE at cycle n and the grant is effective (`busy`=1) at n+1. The first beat can transfer at n+1.
- Within a packet: zero-cycle combinational path (valid/data/last forward, ready backward) at 1 beat per cycle.
- Between packets: exactly one IDLE cycle after each `tlast` beat.
  - A back-to-back stream of single-beat packets therefore achieves 50% throughput.
  - A packet of L beats with no stalls occupies L+1 cycles including arbitration.
- Fairness: each continuously requesting requester is granted within `NUM_REQ`-1 intervening packets.

## Structure
- Package `axis_arb_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t`.
  - function `rr_next(ptr, NUM_REQ)` for the modulo increment.
- Sub-module `rr_priority_pick`:
  - Purely combinational, parameterised on `NUM_REQ`.
  - Inputs: request vector and `ptr`. Outputs: `found` and `idx`.
  - Implemented as a double-width masked priority encoder.
- Top level holds the FSM, the `grant_idx`/`ptr` registers and the output mux.

## Test plan
- **Single requester:** only requester 2 sends a 4-beat packet, tdata 0xA0..0xA3, with `m_axis_tready`=1.
  - `grant`=4'b0100 from cycle 1, four beats out in cycles 1-4 in order.
  - IDLE in cycle 5, then `ptr`=3.
- **All four request continuously:** each sends 2-beat packets.
  - Grant order is 0,1,2,3,0,1.
  - Exactly one `busy`=0 cycle between packets. No beat comes from a non-granted input.
- **Wrap and skip:** set `ptr`=3 by completing a packet from requester 2. Then requesters 1 and 3 request together.
  - Requester 3 is granted first, then requester 1.
- **Interruptions:** `axi_master_model`/`axi_slave_model` run with random tvalid and tready gaps (seed 2727272), 3 requesters, packet lengths 16..32 beats.
  - Each output packet is contiguous and matches exactly one source packet.
  - Total beat count is preserved.
- **Reset mid-packet:** assert `rst` for 1 cycle at beat 2 of a 5-beat packet from requester 1.
  - During reset, `m_axis_tvalid`=0 and all readies=0.
  - After reset, `grant`=0 and `ptr`=0. The next request from requester 1 is granted with a fresh bubble.
- **Granted source stalls:** the granted requester drops `tvalid` for 3 cycles mid-packet while others request.
  - Lock is held and no other requester gets ready until `tlast` transfers.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-locked round-robin AXI-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Cyclic increment of a requester index: NUM_REQ-1 wraps back to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
    return (ptr + 32'd1 >= num_req) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: lowest set request at or after ptr, wrapping modulo NUM_REQ.
// The request vector is doubled; the lower copy is masked below ptr so a plain
// lowest-bit search over both copies yields the cyclic scan order.
module rr_priority_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] masked;

  assign req_dbl = {req_i, req_i};

  generate
    for (genvar gi = 0; gi < 2 * NUM_REQ; gi++) begin : g_mask
      if (gi < NUM_REQ) begin : g_low
        localparam logic [IDX_W-1:0] POS = IDX_W'(gi);
        assign masked[gi] = req_dbl[gi] & (POS >= ptr_i);
      end else begin : g_high
        assign masked[gi] = req_dbl[gi];
      end
    end
  endgenerate

  // Lowest set bit of the masked double vector wins; fold it back into range.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int j = 2 * NUM_REQ - 1; j >= 0; j--) begin
      if (masked[j]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(j % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one AXI-Stream output among
// NUM_REQ requesters. A grant is held until the owner's tlast beat transfers,
// then priority passes to the next index. Pure combinational forwarding while
// locked; no data storage.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]            s_axis_tvalid,
  input  logic [NUM_REQ-1:0]            s_axis_tlast,
  output logic [NUM_REQ-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
      assign req_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_priority_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req_i   (s_axis_tvalid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // State, owner index and next-priority pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      grant_idx_q <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  // Arbitration, packet-end detection and the owner's forwarding mux.
  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    ptr_d         = ptr_q;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    grant         = '0;
    busy          = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          state_d     = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        busy         = 1'b1;
        grant        = NUM_REQ'(1) << grant_idx_q;
        m_axis_tdata = req_data[grant_idx_q];
        m_axis_tlast = s_axis_tlast[grant_idx_q];
        // Handshakes are blocked during reset so a partial packet cannot leak a beat.
        m_axis_tvalid              = s_axis_tvalid[grant_idx_q] & ~rst;
        s_axis_tready[grant_idx_q] = m_axis_tready & ~rst;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          state_d = ARB_IDLE;
          ptr_d   = IDX_W'(rr_next(32'(grant_idx_q), 32'(NUM_REQ)));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios plus randomized interrupted
// traffic, checked cycle by cycle against a behavioural arbitration model and
// an in-order beat scoreboard.
module tb_axis_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid, m_tlast, m_tready;
  logic [N-1:0]    grant;
  logic            busy;

  axis_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .grant(grant), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: current owner (-1 when idle) and next-priority index.
  int owner, ptr;
  int grant_log[$];

  // Source models.
  int            src_left[N], src_len[N], src_beat[N], src_pkt[N];
  int            src_lmin[N], src_lmax[N], stall_beat[N], stall_cnt[N];
  logic [DW-1:0] src_base[N];
  bit            src_hold[N];
  int            vgap, rgap;

  logic [DW:0]   exp_q[$];
  int            beats_out, sent_total, cyc;
  logic [DW-1:0] out_data_log[$];
  int            out_cyc_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int log_at(input int k);
    return (k < grant_log.size()) ? grant_log[k] : -1;
  endfunction

  function automatic bit all_idle();
    bit r = (owner < 0);
    for (int i = 0; i < N; i++) if (src_left[i] > 0 || src_hold[i]) r = 0;
    return r;
  endfunction

  task automatic src_setup(input int i, input int npk, input int lmin, input int lmax,
                           input logic [DW-1:0] base);
    src_left[i] = npk;  src_lmin[i] = lmin;  src_lmax[i] = lmax;
    src_len[i]  = $urandom_range(lmax, lmin);
    src_beat[i] = 0;    src_pkt[i] = 0;      src_base[i] = base;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!src_hold[i] && src_left[i] > 0) begin
        if (stall_cnt[i] > 0) stall_cnt[i]--;
        else if ($urandom_range(99) >= vgap) src_hold[i] = 1'b1;
      end
      s_tvalid[i] = src_hold[i];
      if (src_hold[i]) begin
        s_tdata[i*DW +: DW] = src_base[i] + DW'(src_pkt[i] * 256 + src_beat[i]);
        s_tlast[i]          = (src_beat[i] == src_len[i] - 1);
      end else begin
        s_tdata[i*DW +: DW] = $urandom();
        s_tlast[i]          = 1'($urandom_range(1));
      end
    end
    m_tready = ($urandom_range(99) >= rgap);
  endtask

  task automatic cycle();
    logic [N-1:0]  e_grant, e_ready;
    logic          e_valid, e_last, e_busy;
    logic [DW-1:0] e_data;
    logic [DW:0]   beat;
    drive();
    @(negedge clk);
    e_grant = '0; e_ready = '0; e_valid = 1'b0; e_last = 1'b0; e_busy = 1'b0; e_data = '0;
    if (owner >= 0) begin
      e_busy         = 1'b1;
      e_grant[owner] = 1'b1;
      e_data         = s_tdata[owner*DW +: DW];
      e_last         = s_tlast[owner];
      if (!rst) begin
        e_valid        = s_tvalid[owner];
        e_ready[owner] = m_tready;
      end
    end
    chk("busy", busy, e_busy);
    chk("grant", grant, e_grant);
    chk("m_tvalid", m_tvalid, e_valid);
    chk("s_tready", s_tready, e_ready);
    chk("m_tdata", m_tdata, e_data);
    chk("m_tlast", m_tlast, e_last);
    // Input-side handshakes as the sources see them.
    for (int i = 0; i < N; i++) begin
      if (s_tvalid[i] && s_tready[i]) begin
        exp_q.push_back({s_tlast[i], s_tdata[i*DW +: DW]});
        src_hold[i] = 1'b0;
        src_beat[i]++;
        if (src_beat[i] == stall_beat[i]) stall_cnt[i] = 3;
        if (src_beat[i] == src_len[i]) begin
          sent_total += src_len[i];
          src_pkt[i]++;
          src_left[i]--;
          src_beat[i] = 0;
          src_len[i]  = $urandom_range(src_lmax[i], src_lmin[i]);
        end
      end
    end
    if (m_tvalid && m_tready) begin
      beats_out++;
      out_data_log.push_back(m_tdata);
      out_cyc_log.push_back(cyc);
      chk("sb_have", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        beat = exp_q.pop_front();
        chk("sb_beat", {m_tlast, m_tdata}, beat);
      end
    end
    if (rst) begin
      // Partial packets are abandoned; sources restart with a fresh packet.
      for (int i = 0; i < N; i++) begin
        if (src_beat[i] > 0 || src_hold[i]) begin
          sent_total += src_beat[i];
          src_beat[i] = 0;
          src_pkt[i]++;
          src_hold[i] = 1'b0;
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      owner = -1;
      ptr   = 0;
    end else if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (s_tvalid[(ptr + k) % N]) begin
          owner = (ptr + k) % N;
          grant_log.push_back(owner);
          break;
        end
      end
    end else if (s_tvalid[owner] && m_tready && s_tlast[owner]) begin
      ptr   = (owner + 1) % N;
      owner = -1;
    end
    cyc++;
    #1;
  endtask

  task automatic run(input string tag, input int max_cycles);
    bit done;
    for (int c = 0; c < max_cycles && !all_idle(); c++) cycle();
    done = all_idle();
    chk(tag, done, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
    vgap = 0; rgap = 0; beats_out = 0; sent_total = 0; cyc = 0;
    for (int i = 0; i < N; i++) begin
      src_left[i] = 0; src_hold[i] = 0; stall_beat[i] = -1; stall_cnt[i] = 0;
      src_beat[i] = 0; src_pkt[i] = 0; src_len[i] = 1; src_lmin[i] = 1; src_lmax[i] = 1;
      src_base[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    owner = -1; ptr = 0;
    do_reset();

    // Single requester: requester 2, 4 beats 0xA0..0xA3.
    cyc = 0; out_data_log.delete(); out_cyc_log.delete(); grant_log.delete();
    src_setup(2, 1, 4, 4, 32'hA0);
    run("t1_done", 20);
    chk("t1_owner", log_at(0), 2);
    chk("t1_nbeats", out_data_log.size(), 4);
    for (int k = 0; k < 4 && k < out_data_log.size(); k++) begin
      chk("t1_data", out_data_log[k], 32'hA0 + k);
      chk("t1_cycle", out_cyc_log[k], k + 1);
    end
    chk("t1_idle_c5", busy, 0);
    cycle();

    // Wrap and skip: pointer now at 3, requesters 1 and 3 together.
    grant_log.delete();
    src_setup(1, 1, 2, 2, 32'h0100_0000);
    src_setup(3, 1, 2, 2, 32'h0300_0000);
    run("t3_done", 30);
    chk("t3_first", log_at(0), 3);
    chk("t3_second", log_at(1), 1);

    // All four requesting continuously with 2-beat packets.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) src_setup(i, 2, 2, 2, DW'(i) << 24);
    run("t2_done", 100);
    for (int k = 0; k < 6; k++) chk("t2_order", log_at(k), k % 4);

    // Reset mid-packet: move pointer to 2, then reset at beat 2 of a 5-beat packet.
    src_setup(1, 1, 1, 1, 32'h0110_0000);
    run("t5_pre", 10);
    src_setup(1, 1, 5, 5, 32'h0120_0000);
    for (int c = 0; c < 50 && src_beat[1] != 2; c++) cycle();
    chk("t5_reach", src_beat[1], 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_grant", grant, 0);
    chk("t5_busy", busy, 0);
    grant_log.delete();
    src_setup(3, 1, 2, 2, 32'h0330_0000);
    run("t5_done", 30);
    chk("t5_first", log_at(0), 1);
    chk("t5_second", log_at(1), 3);

    // Granted source stalls 3 cycles mid-packet while others request.
    do_reset();
    grant_log.delete();
    src_setup(0, 1, 6, 6, 32'h0040_0000);
    stall_beat[0] = 2;
    src_setup(1, 1, 3, 3, 32'h0140_0000);
    src_setup(2, 1, 3, 3, 32'h0240_0000);
    run("t6_done", 40);
    chk("t6_order0", log_at(0), 0);
    chk("t6_order1", log_at(1), 1);
    chk("t6_order2", log_at(2), 2);
    stall_beat[0] = -1;

    // Interrupted random traffic: 3 requesters, 16..32-beat packets.
    void'($urandom(2727272));
    vgap = 30; rgap = 30;
    for (int i = 0; i < 3; i++) src_setup(i, 3, 16, 32, DW'(i + 5) << 24);
    run("t4_done", 3000);
    vgap = 0; rgap = 0;
    cycle();

    chk("beat_total", beats_out, sent_total);
    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
